// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace buffer: one stored trace record, the
// trigger-mode state encoding and a saturating counter helper.
package commit_trace_pkg;

  // Widest PC/data the stored record can carry; XLEN of the buffer must not exceed it.
  localparam int unsigned TRACE_XLEN = 32;
  localparam int unsigned SEQ_W      = 16;

  localparam logic MODE_STREAM  = 1'b0;
  localparam logic MODE_TRIGGER = 1'b1;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_POST   = 2'd1,
    ST_FROZEN = 2'd2
  } trace_state_t;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [4:0]            rd;
    logic [TRACE_XLEN-1:0] data;
    logic [SEQ_W-1:0]      seq;
  } trace_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/commit_trace_buf_ram.sv
// Trace entry storage: DEPTH records, one synchronous write port and one
// combinational read port. The array is deliberately not reset.
module trace_ram
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  trace_entry_t wdata_i,
  input  logic [AW-1:0] raddr_i,
  output trace_entry_t rdata_o
);

  trace_entry_t mem_q [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_buf.sv
// Commit trace buffer: records retired-instruction events either as a
// draining FIFO (STREAM) or as a pre/post-trigger window (TRIGGER).
module commit_trace_buf
  import commit_trace_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned POST_TRIG = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mode,
  input  logic                     filter_x0,
  input  logic                     cap_valid,
  input  logic [XLEN-1:0]          cap_pc,
  input  logic [4:0]               cap_rd,
  input  logic [XLEN-1:0]          cap_data,
  input  logic [XLEN-1:0]          trig_pc,
  input  logic                     rearm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [4:0]               out_rd,
  output logic [XLEN-1:0]          out_data,
  output logic [15:0]              out_seq,
  output logic [$clog2(DEPTH):0]   count,
  output logic [15:0]              drop_cnt,
  output logic                     frozen
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] POST_LOAD = CW'(POST_TRIG);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [CW-1:0]  post_q, post_d;
  logic [15:0]    seq_q, seq_d;
  logic [15:0]    drop_q, drop_d;
  trace_state_t   state_q, state_d;
  logic           mode_q;
  logic           out_valid_q, out_valid_d;
  logic           frozen_q;
  trace_entry_t   head_q, head_d;

  logic           eligible_s;
  logic           mode_chg_s;
  logic           full_s;
  logic           pop_s;
  logic           trig_hit_s;
  logic           push_s;
  trace_entry_t   wr_entry_s;
  trace_entry_t   ram_rdata_s;

  assign eligible_s = cap_valid && !(filter_x0 && (cap_rd == 5'd0));
  assign mode_chg_s = (mode != mode_q);
  assign full_s     = (count_q == FULL_CNT);
  assign pop_s      = out_valid_q && out_ready;
  assign trig_hit_s = (cap_pc == trig_pc);

  assign wr_entry_s.pc   = TRACE_XLEN'(cap_pc);
  assign wr_entry_s.rd   = cap_rd;
  assign wr_entry_s.data = TRACE_XLEN'(cap_data);
  assign wr_entry_s.seq  = seq_q;

  trace_ram #(
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry_s),
    .raddr_i (rd_ptr_d),
    .rdata_o (ram_rdata_s)
  );

  // Next-state for pointers, occupancy, counters and the trigger FSM
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    post_d   = post_q;
    drop_d   = drop_q;
    state_d  = state_q;
    push_s   = 1'b0;

    // Every commit is numbered, so filtered commits leave visible gaps in seq.
    if (cap_valid) begin
      seq_d = seq_q + 16'd1;
    end else begin
      seq_d = seq_q;
    end

    if (mode_chg_s) begin
      wr_ptr_d = {AW{1'b0}};
      rd_ptr_d = {AW{1'b0}};
      count_d  = {CW{1'b0}};
      post_d   = {CW{1'b0}};
      state_d  = ST_ARMED;
    end else if (mode == MODE_STREAM) begin
      push_s   = eligible_s && (!full_s || pop_s);
      wr_ptr_d = wr_ptr_q + AW'(push_s);
      rd_ptr_d = rd_ptr_q + AW'(pop_s);
      count_d  = count_q + CW'(push_s) - CW'(pop_s);
      if (eligible_s && full_s && !pop_s) begin
        drop_d = sat_inc16(drop_q);
      end else begin
        drop_d = drop_q;
      end
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          push_s   = eligible_s;
          wr_ptr_d = wr_ptr_q + AW'(push_s);
          // A full window slides: the oldest entry is overwritten in place.
          if (push_s && full_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
          end else begin
            count_d = count_q + CW'(push_s);
          end
          if (push_s && (state_q == ST_ARMED) && trig_hit_s) begin
            state_d = ST_POST;
            post_d  = POST_LOAD;
          end else if (push_s && (state_q == ST_POST)) begin
            post_d = post_q - CW'(1);
            if (post_q == CW'(1)) begin
              state_d = ST_FROZEN;
            end else begin
              state_d = ST_POST;
            end
          end else begin
            post_d = post_q;
          end
        end
        ST_FROZEN: begin
          if (rearm) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
            post_d   = {CW{1'b0}};
            state_d  = ST_ARMED;
          end else begin
            rd_ptr_d = rd_ptr_q + AW'(pop_s);
            count_d  = count_q - CW'(pop_s);
          end
        end
        default: begin
          wr_ptr_d = {AW{1'b0}};
          rd_ptr_d = {AW{1'b0}};
          count_d  = {CW{1'b0}};
          post_d   = {CW{1'b0}};
          state_d  = ST_ARMED;
        end
      endcase
    end
  end

  // Next head entry and visibility; a write landing on the new head bypasses the array
  always_comb begin
    if (count_d == CW'(0)) begin
      head_d = '0;
    end else if (push_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_entry_s;
    end else begin
      head_d = ram_rdata_s;
    end
    out_valid_d = (count_d != CW'(0)) && ((mode == MODE_STREAM) || (state_d == ST_FROZEN));
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= {AW{1'b0}};
      rd_ptr_q    <= {AW{1'b0}};
      count_q     <= {CW{1'b0}};
      post_q      <= {CW{1'b0}};
      seq_q       <= 16'd0;
      drop_q      <= 16'd0;
      state_q     <= ST_ARMED;
      mode_q      <= MODE_STREAM;
      out_valid_q <= 1'b0;
      frozen_q    <= 1'b0;
      head_q      <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      post_q      <= post_d;
      seq_q       <= seq_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      mode_q      <= mode;
      out_valid_q <= out_valid_d;
      frozen_q    <= (state_d == ST_FROZEN);
      head_q      <= head_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = head_q.pc[XLEN-1:0];
  assign out_rd    = head_q.rd;
  assign out_data  = head_q.data[XLEN-1:0];
  assign out_seq   = head_q.seq;
  assign count     = count_q;
  assign drop_cnt  = drop_q;
  assign frozen    = frozen_q;

endmodule

// File: tb/tb_commit_trace_buf.sv
// Directed self-checking bench for commit_trace_buf (STREAM and TRIGGER modes).
module tb_commit_trace_buf;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned DEPTH     = 16;
  localparam int unsigned POST_TRIG = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            mode;
  logic            filter_x0;
  logic            cap_valid;
  logic [XLEN-1:0] cap_pc;
  logic [4:0]      cap_rd;
  logic [XLEN-1:0] cap_data;
  logic [XLEN-1:0] trig_pc;
  logic            rearm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [XLEN-1:0] out_data;
  logic [15:0]     out_seq;
  logic [4:0]      count;
  logic [15:0]     drop_cnt;
  logic            frozen;

  int n_checks = 0;
  int n_fail   = 0;

  commit_trace_buf #(
    .XLEN(XLEN), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
  ) dut (
    .clk(clk), .reset(reset), .mode(mode), .filter_x0(filter_x0),
    .cap_valid(cap_valid), .cap_pc(cap_pc), .cap_rd(cap_rd), .cap_data(cap_data),
    .trig_pc(trig_pc), .rearm(rearm), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rd(out_rd), .out_data(out_data), .out_seq(out_seq),
    .count(count), .drop_cnt(drop_cnt), .frozen(frozen)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic m);
    reset = 1'b1; mode = m; filter_x0 = 1'b0; cap_valid = 1'b0;
    cap_pc = 32'd0; cap_rd = 5'd0; cap_data = 32'd0;
    trig_pc = 32'h100; rearm = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic commit(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    cap_valid = 1'b1; cap_pc = pc; cap_rd = rd; cap_data = data;
    tick();
    cap_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;

    // Reset values while reset is held
    reset = 1'b1; mode = 1'b0; filter_x0 = 1'b0; cap_valid = 1'b0;
    cap_pc = 32'd0; cap_rd = 5'd0; cap_data = 32'd0;
    trig_pc = 32'h100; rearm = 1'b0; out_ready = 1'b0;
    tick();
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_seq", 64'(out_seq), 64'd0);
    check_eq("rst_pc", 64'(out_pc), 64'd0);
    check_eq("rst_drop", 64'(drop_cnt), 64'd0);
    check_eq("rst_frozen", 64'(frozen), 64'd0);

    // STREAM: 20 commits with no drain -> 16 held, 4 dropped
    do_reset(1'b0);
    for (int i = 0; i < 20; i++) begin
      commit(32'(4 * i), 5'd1, 32'(32'hA000 + i));
      if (i == 0) begin
        check_eq("lat_valid", 64'(out_valid), 64'd1);
        check_eq("lat_seq", 64'(out_seq), 64'd0);
        check_eq("lat_data", 64'(out_data), 64'hA000);
      end
    end
    check_eq("s_count", 64'(count), 64'd16);
    check_eq("s_drop", 64'(drop_cnt), 64'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_eq("s_drain_seq", 64'(out_seq), 64'(k));
      check_eq("s_drain_pc", 64'(out_pc), 64'(4 * k));
      tick();
    end
    out_ready = 1'b0;
    check_eq("s_empty_valid", 64'(out_valid), 64'd0);
    check_eq("s_empty_count", 64'(count), 64'd0);

    // STREAM full: pop and push together, then a drop, then mode flush
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      commit(32'(i), 5'd2, 32'(i));
    end
    check_eq("f_count", 64'(count), 64'd16);
    out_ready = 1'b1;
    commit(32'h40, 5'd2, 32'd16);
    out_ready = 1'b0;
    check_eq("f_pp_count", 64'(count), 64'd16);
    check_eq("f_pp_drop", 64'(drop_cnt), 64'd0);
    check_eq("f_pp_head", 64'(out_seq), 64'd1);
    commit(32'h44, 5'd2, 32'd17);
    check_eq("f_drop", 64'(drop_cnt), 64'd1);
    check_eq("f_drop_count", 64'(count), 64'd16);
    mode = 1'b1;
    tick();
    check_eq("mc_count", 64'(count), 64'd0);
    check_eq("mc_valid", 64'(out_valid), 64'd0);
    check_eq("mc_drop", 64'(drop_cnt), 64'd1);
    mode = 1'b0;
    tick();
    commit(32'h48, 5'd2, 32'd18);
    check_eq("mc_seq_kept", 64'(out_seq), 64'd18);
    check_eq("mc_new_valid", 64'(out_valid), 64'd1);

    // x0 filter: rd=0 commits are dropped but still numbered
    do_reset(1'b0);
    filter_x0 = 1'b1;
    commit(32'h10, 5'd0, 32'd1);
    commit(32'h14, 5'd3, 32'd2);
    commit(32'h18, 5'd0, 32'd3);
    commit(32'h1C, 5'd7, 32'd4);
    check_eq("x0_count", 64'(count), 64'd2);
    check_eq("x0_rd0", 64'(out_rd), 64'd3);
    check_eq("x0_seq0", 64'(out_seq), 64'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("x0_rd1", 64'(out_rd), 64'd7);
    check_eq("x0_seq1", 64'(out_seq), 64'd3);
    filter_x0 = 1'b0;

    // TRIGGER: hit at i=20 (a second hit at i=24 is ignored), freeze after i=28
    do_reset(1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      pc = ((i == 20) || (i == 24)) ? 32'h100 : 32'(4 * i);
      commit(pc, 5'd4, 32'(i));
      if (i == 19) begin
        check_eq("t_armed_count", 64'(count), 64'd16);
        check_eq("t_armed_valid", 64'(out_valid), 64'd0);
        out_ready = 1'b0;
      end
      if (i == 27) check_eq("t_post_frozen", 64'(frozen), 64'd0);
      if (i == 28) check_eq("t_frozen", 64'(frozen), 64'd1);
    end
    check_eq("t_count", 64'(count), 64'd16);
    check_eq("t_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_eq("t_drain_seq", 64'(out_seq), 64'(13 + k));
      tick();
    end
    out_ready = 1'b0;
    check_eq("t_drained", 64'(count), 64'd0);
    check_eq("t_drained_valid", 64'(out_valid), 64'd0);

    // FROZEN ignores commits; rearm restarts capture
    commit(32'h500, 5'd4, 32'd30);
    commit(32'h504, 5'd4, 32'd31);
    check_eq("fz_nocap", 64'(count), 64'd0);
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    check_eq("ra_frozen", 64'(frozen), 64'd0);
    check_eq("ra_count", 64'(count), 64'd0);
    commit(32'h100, 5'd5, 32'd32);
    check_eq("ra_cap", 64'(count), 64'd1);
    check_eq("ra_valid", 64'(out_valid), 64'd0);
    for (int j = 0; j < 8; j++) begin
      commit(32'(32'h300 + 4 * j), 5'd5, 32'(33 + j));
    end
    check_eq("ra_frozen2", 64'(frozen), 64'd1);
    check_eq("ra_count2", 64'(count), 64'd9);
    check_eq("ra_head", 64'(out_seq), 64'd32);
    rearm = 1'b1;
    tick();
    rearm = 1'b0;
    check_eq("ra_flush", 64'(count), 64'd0);
    check_eq("ra_flush_valid", 64'(out_valid), 64'd0);

    // Asynchronous reset during POST
    do_reset(1'b1);
    commit(32'h100, 5'd6, 32'd1);
    commit(32'h104, 5'd6, 32'd2);
    check_eq("ar_pre_count", 64'(count), 64'd2);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_count", 64'(count), 64'd0);
    check_eq("ar_pc", 64'(out_pc), 64'd0);
    check_eq("ar_frozen", 64'(frozen), 64'd0);
    tick();
    reset = 1'b0;

    // Asynchronous reset mid-drain in STREAM
    do_reset(1'b0);
    commit(32'h20, 5'd1, 32'd1);
    commit(32'h24, 5'd1, 32'd2);
    commit(32'h28, 5'd1, 32'd3);
    out_ready = 1'b1;
    tick();
    check_eq("ad_mid_seq", 64'(out_seq), 64'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("ad_count", 64'(count), 64'd0);
    check_eq("ad_valid", 64'(out_valid), 64'd0);
    check_eq("ad_seq", 64'(out_seq), 64'd0);
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
